// File: rtl/fpu_result_collector_pkg.sv
// Shared types for the FPU result collector: IEEE status flag layout.
package fpu_result_collector_pkg;

    localparam int unsigned NUM_FLAGS = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/fpu_res_fifo.sv
// First-word-fall-through FIFO: registered storage, wrapping pointers and occupancy level.
module fpu_res_fifo
    import fpu_result_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32 + NUM_FLAGS,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             pop_i,
    output logic [DW-1:0]    rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;

endmodule

// File: rtl/fpu_result_collector.sv
// Buffers FPU results/status in a FWFT FIFO, accumulates sticky fflags and counts accepted results.
module fpu_result_collector
    import fpu_result_collector_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [WIDTH-1:0]             fpu_result_i,
    input  logic [NUM_FLAGS-1:0]         fpu_status_i,
    input  logic                         fpu_valid_i,
    output logic                         fpu_ready_o,
    output logic [WIDTH-1:0]             res_data_o,
    output logic [NUM_FLAGS-1:0]         res_status_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [NUM_FLAGS-1:0]         fflags_o,
    output logic [CNT_W-1:0]             res_count_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned EW = WIDTH + NUM_FLAGS;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] rd_data;
    status_t       fflags_q;
    logic [CNT_W-1:0] count_q;

    // Ready comes only from registered occupancy; consumer ready never reaches the FPU side.
    assign push        = fpu_valid_i & ~full;
    assign pop         = ~empty & res_ready_i;
    assign fpu_ready_o = ~full;
    assign res_valid_o = ~empty;

    fpu_res_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .wr_data_i ({fpu_result_i, fpu_status_i}),
        .pop_i     (pop),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level_o)
    );

    assign {res_data_o, res_status_o} = rd_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            fflags_q <= '0;
            count_q  <= '0;
        end else if (push) begin
            fflags_q <= status_t'(fflags_q | fpu_status_i);
            if (count_q != '1) count_q <= count_q + CNT_W'(1);
        end
    end

    assign fflags_o    = fflags_q;
    assign res_count_o = count_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench: reference model with scoreboard queue plus table-driven and hand-written sequences.
module tb_fpu_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_status;
    logic        fpu_valid;
    logic        fpu_ready, fpu_ready2;
    logic [31:0] res_data, res_data2;
    logic [4:0]  res_status, res_status2;
    logic        res_valid, res_valid2;
    logic        res_ready;
    logic [4:0]  fflags, fflags2;
    logic [15:0] count;
    logic [1:0]  count2;
    logic [2:0]  level, level2;

    always #5 clk = ~clk;

    fpu_result_collector #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_valid_i(fpu_valid),
        .fpu_ready_o(fpu_ready), .res_data_o(res_data), .res_status_o(res_status),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .fflags_o(fflags),
        .res_count_o(count), .level_o(level)
    );

    fpu_result_collector #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_valid_i(fpu_valid),
        .fpu_ready_o(fpu_ready2), .res_data_o(res_data2), .res_status_o(res_status2),
        .res_valid_o(res_valid2), .res_ready_i(res_ready), .fflags_o(fflags2),
        .res_count_o(count2), .level_o(level2)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
    } ent_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        int          exp_level;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    ent_t        q[$];
    int          m_level;
    int          m_count;
    int          m_count2;
    logic [4:0]  m_flags;
    int          tests  = 0;
    int          failed = 0;
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_level  = 0;
        m_count  = 0;
        m_count2 = 0;
        m_flags  = '0;
    endtask

    // Asynchronous reset: outputs are checked while rst_n is low and no clock edge has occurred.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_ready", fpu_ready, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_data", res_data, 0);
        chk("rst_status", res_status, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_count", count, 0);
        chk("rst_count_sat", count2, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                         input logic r, input logic c);
        fpu_valid  = v;
        fpu_result = d;
        fpu_status = s;
        res_ready  = r;
        clear      = c;
        @(negedge clk);
        chk("ready", fpu_ready, m_level != 4);
        chk("valid", res_valid, m_level != 0);
        chk("level", level, m_level);
        if (m_level != 0) begin
            chk("sb_data", res_data, q[0].d);
            chk("sb_status", res_status, q[0].s);
        end
        chk("fflags", fflags, m_flags);
        chk("count", count, m_count);
        chk("count_sat", count2, m_count2);
    endtask

    task automatic advance();
        logic push, pop;
        ent_t e;
        @(posedge clk);
        push = fpu_valid && (m_level != 4);
        pop  = (m_level != 0) && res_ready;
        if (pop) e = q.pop_front();
        if (push) q.push_back('{fpu_result, fpu_status});
        if (clear) begin
            m_flags  = '0;
            m_count  = 0;
            m_count2 = 0;
        end else if (push) begin
            m_flags = m_flags | fpu_status;
            if (m_count < 65535) m_count++;
            if (m_count2 < 3) m_count2++;
        end
        m_level = m_level + int'(push) - int'(pop);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic r, input logic c);
        drive(v, d, s, r, c);
        advance();
    endtask

    initial begin
        rst_n = 1'b1; clear = 1'b0; fpu_valid = 1'b0; res_ready = 1'b0;
        fpu_result = '0; fpu_status = '0;
        #1;
        do_reset();

        // 1: idle after reset
        cyc(0, 32'h0, 5'h0, 0, 0);
        cyc(0, 32'h0, 5'h0, 1, 0);

        // 2: single push, visible next cycle, popped after
        cyc(1, 32'h3F80_0000, 5'b00001, 1, 0);
        drive(0, 32'h0, 5'h0, 1, 0);
        chk("t2_data", res_data, 32'h3F80_0000);
        chk("t2_valid", res_valid, 1'b1);
        chk("t2_fflags", fflags, 5'b00001);
        advance();
        drive(0, 32'h0, 5'h0, 1, 0);
        chk("t2_level", level, 0);
        advance();

        // 3: fill to full under backpressure, then drain in order
        tbl[0] = '{1'b1, 32'h1, 1'b0, 0, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h2, 1'b0, 1, 1'b1, 1'b1, 32'h1};
        tbl[2] = '{1'b1, 32'h3, 1'b0, 2, 1'b1, 1'b1, 32'h1};
        tbl[3] = '{1'b1, 32'h4, 1'b0, 3, 1'b1, 1'b1, 32'h1};
        tbl[4] = '{1'b1, 32'h5, 1'b0, 4, 1'b0, 1'b1, 32'h1};
        tbl[5] = '{1'b1, 32'h5, 1'b1, 4, 1'b0, 1'b1, 32'h1};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b1, 32'h2};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 2, 1'b1, 1'b1, 32'h3};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1, 1'b1, 1'b1, 32'h4};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 0, 1'b1, 1'b0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, 5'h0, tbl[i].r, 0);
            chk($sformatf("t3_level[%0d]", i), level, tbl[i].exp_level);
            chk($sformatf("t3_ready[%0d]", i), fpu_ready, tbl[i].exp_ready);
            chk($sformatf("t3_valid[%0d]", i), res_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("t3_data[%0d]", i), res_data, tbl[i].exp_data);
            advance();
        end

        // 4: steady push+pop at level 2, pointers wrap several times
        cyc(1, 32'hA000_0100, 5'h02, 0, 0);
        cyc(1, 32'hA000_0101, 5'h04, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'hB000_0000 + 32'(i), 5'(i), 1, 0);
            chk("t4_level", level, 2);
            advance();
        end
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 5'h0, 1, 0);

        // 5: sticky flags, then clear with a simultaneous push
        do_reset();
        cyc(1, 32'hC000_0001, 5'b10000, 1, 0);
        cyc(1, 32'hC000_0002, 5'b00100, 1, 0);
        drive(0, 32'h0, 5'h0, 0, 0);
        chk("t5_fflags", fflags, 5'b10100);
        chk("t5_count", count, 2);
        advance();
        drive(1, 32'hC000_0003, 5'b00001, 0, 1);
        chk("t5_level_pre", level, 1);
        advance();
        drive(0, 32'h0, 5'h0, 0, 0);
        chk("t5_clr_fflags", fflags, 5'b00000);
        chk("t5_clr_count", count, 0);
        chk("t5_clr_level", level, 2);
        advance();
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 5'h0, 1, 0);

        // 6: counter saturation in the narrow instance, then async reset mid-burst
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 32'hD000_0000 + 32'(i), 5'h08, 1, 0);
        drive(0, 32'h0, 5'h0, 0, 0);
        chk("t6_sat_count", count2, 3);
        chk("t6_count", count, 5);
        advance();
        cyc(1, 32'hE000_0001, 5'h10, 0, 0);
        cyc(1, 32'hE000_0002, 5'h01, 0, 0);
        fpu_valid = 1'b1;
        fpu_result = 32'hE000_0003;
        chk("t6_level_pre", level, 3);
        do_reset();
        cyc(0, 32'h0, 5'h0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
